// File: rtl/math_adder_pkg.sv
// Shared types and helpers for the Brent-Kung adder/subtractor.
package math_adder_pkg;

    localparam int unsigned MATH_BK_MAX_N = 128;

    // Propagate/generate pair for one prefix node.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Prefix-tree depth for an N-bit operand.
    function automatic int unsigned bk_levels(input int unsigned n);
        return int'($clog2(n));
    endfunction

    // Prefix operator: hi covers the more significant span, lo the less significant one.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage

// File: rtl/math_adder_bk_prefix_tree.sv
// Brent-Kung up-sweep/down-sweep over N+1 nodes (node 0 carries the carry-in).
// REG_MID=1 places a register between the sweeps, loaded when en is high.
module math_adder_bk_prefix_tree
    import math_adder_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned REG_MID = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  pg_t  [N:0]   pg_in,
    output logic [N:0]   gg_c,
    output logic [N-1:0] bit_p_c
);

    localparam int unsigned LV = bk_levels(N) + 1;

    pg_t  [N:0]   up_c;
    pg_t  [N:0]   dn_in;
    pg_t  [N:0]   dn_c;
    logic [N-1:0] raw_p;

    // Per-bit propagate, needed by the sum stage after the tree.
    always_comb begin
        raw_p = '0;
        for (int k = 0; k < int'(N); k++) begin
            raw_p[k] = pg_in[k + 1].p;
        end
    end

    // Up-sweep: each node at odd span position absorbs its left sibling group.
    always_comb begin
        up_c = pg_in;
        for (int l = 0; l < int'(LV); l++) begin
            for (int i = 0; i <= int'(N); i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    up_c[i] = pg_combine(up_c[i], up_c[i - (1 << l)]);
                end
            end
        end
    end

    generate
        if (REG_MID != 0) begin : g_mid
            pg_t  [N:0]   mid_q;
            logic [N-1:0] bit_p_q;

            // Mid-tree boundary holds the completed up-sweep.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid_q   <= '0;
                    bit_p_q <= '0;
                end else if (en) begin
                    mid_q   <= up_c;
                    bit_p_q <= raw_p;
                end
            end

            assign dn_in   = mid_q;
            assign bit_p_c = bit_p_q;
        end else begin : g_nomid
            logic unused_mid;
            assign unused_mid = ^{clk, rst_n, en};
            assign dn_in      = up_c;
            assign bit_p_c    = raw_p;
        end
    endgenerate

    // Down-sweep: fill the remaining nodes from the nearest complete prefix on their right.
    always_comb begin
        dn_c = dn_in;
        gg_c = '0;
        for (int l = int'(LV) - 1; l >= 0; l--) begin
            for (int i = 0; i <= int'(N); i++) begin
                if (((i + 1) >= 3 * (1 << l)) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
                    dn_c[i] = pg_combine(dn_c[i], dn_c[i - (1 << l)]);
                end
            end
        end
        for (int i = 0; i <= int'(N); i++) begin
            gg_c[i] = dn_c[i].g;
        end
    end

endmodule

// File: rtl/math_adder_brent_kung_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshake.
// Define MATH_ADDER_BK_OVF_EN to add the o_overflow port and its logic.
module math_adder_brent_kung_pipe
    import math_adder_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned REG_TREE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_sum,
    output logic         o_carry
`ifdef MATH_ADDER_BK_OVF_EN
    ,
    output logic         o_overflow
`endif
);

    localparam int unsigned STAGES = (REG_TREE != 0) ? 3 : 2;
    localparam int unsigned LAST   = STAGES - 1;

    generate
        if (!((N >= 4) && (N <= MATH_BK_MAX_N) && ((N & (N - 1)) == 0))) begin : g_bad_n
            $error("math_adder_brent_kung_pipe: N must be a power of two in 4..128");
        end
    endgenerate

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] stage_in;
    logic [STAGES-1:0] stage_load;
    logic [N-1:0]      b_eff;
    logic              cin_eff;
    pg_t  [N:0]        pg_c;
    pg_t  [N:0]        s1_pg;
    logic [N:0]        gg_c;
    logic [N-1:0]      bit_p_c;
    logic              mid_en;

    // Ready chain from the output back to the input; a stage loads when ready and fed valid.
    always_comb begin
        stage_in          = {stage_valid[STAGES-2:0], i_valid};
        stage_ready       = '0;
        stage_ready[LAST] = !stage_valid[LAST] || i_ready;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            stage_ready[k] = !stage_valid[k] || stage_ready[k + 1];
        end
        stage_load = stage_ready & stage_in;
    end

    assign o_ready = stage_ready[0];
    assign o_valid = stage_valid[LAST];
    assign mid_en  = (REG_TREE != 0) ? stage_load[1] : 1'b0;

    // Valid bits advance only where the stage is ready; stalled stages hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_valid <= '0;
        end else begin
            stage_valid <= (stage_valid & ~stage_ready) | (stage_in & stage_ready);
        end
    end

    // Operand conditioning: invert B and force carry-in for subtraction.
    always_comb begin
        b_eff      = i_b ^ {N{i_sub}};
        cin_eff    = i_sub | i_cin;
        pg_c       = '0;
        pg_c[0].g  = cin_eff;
        for (int k = 0; k < int'(N); k++) begin
            pg_c[k + 1].p = i_a[k] ^ b_eff[k];
            pg_c[k + 1].g = i_a[k] & b_eff[k];
        end
    end

    // Stage S1 captures the per-bit propagate/generate vector.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_pg <= '0;
        end else if (stage_load[0]) begin
            s1_pg <= pg_c;
        end
    end

    math_adder_bk_prefix_tree #(
        .N       (N),
        .REG_MID (REG_TREE)
    ) u_tree (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .en      (mid_en),
        .pg_in   (s1_pg),
        .gg_c    (gg_c),
        .bit_p_c (bit_p_c)
    );

    // Output stage: sum bits, carry out and optional overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum      <= '0;
            o_carry    <= 1'b0;
`ifdef MATH_ADDER_BK_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else if (stage_load[LAST]) begin
            o_sum      <= gg_c[N-1:0] ^ bit_p_c;
            o_carry    <= gg_c[N];
`ifdef MATH_ADDER_BK_OVF_EN
            o_overflow <= gg_c[N-1] ^ gg_c[N];
`endif
        end
    end

endmodule

// File: tb/tb_math_adder_brent_kung_pipe.sv
// Bench: 8-bit instance with mid-tree register, 32-bit instance without.
module tb_math_adder_brent_kung_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        u8_valid, u8_rdy, u8_cin, u8_sub, u8_ovalid, u8_dready, u8_carry;
    logic [7:0]  u8_opa, u8_opb, u8_sum;
    logic        u32_valid, u32_rdy, u32_cin, u32_sub, u32_ovalid, u32_dready, u32_carry;
    logic [31:0] u32_opa, u32_opb, u32_sum;
`ifdef MATH_ADDER_BK_OVF_EN
    logic        u8_ovf, u32_ovf;
`endif

    math_adder_brent_kung_pipe #(.N(8), .REG_TREE(1)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (u8_valid),
        .o_ready (u8_rdy),
        .i_a     (u8_opa),
        .i_b     (u8_opb),
        .i_cin   (u8_cin),
        .i_sub   (u8_sub),
        .o_valid (u8_ovalid),
        .i_ready (u8_dready),
        .o_sum   (u8_sum),
        .o_carry (u8_carry)
`ifdef MATH_ADDER_BK_OVF_EN
        ,
        .o_overflow (u8_ovf)
`endif
    );

    math_adder_brent_kung_pipe #(.N(32), .REG_TREE(0)) u_dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (u32_valid),
        .o_ready (u32_rdy),
        .i_a     (u32_opa),
        .i_b     (u32_opb),
        .i_cin   (u32_cin),
        .i_sub   (u32_sub),
        .o_valid (u32_ovalid),
        .i_ready (u32_dready),
        .o_sum   (u32_sum),
        .o_carry (u32_carry)
`ifdef MATH_ADDER_BK_OVF_EN
        ,
        .o_overflow (u32_ovf)
`endif
    );

    int   n_checks;
    int   n_errors;
    int   rx8;
    int   rx32;
    res_t q8[$];
    res_t q32[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer add of A and (possibly inverted) B plus effective carry.
    function automatic res_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] be;
        res_t        r;
        mask    = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        be      = (sub ? ~b : b) & mask;
        full    = {1'b0, a & mask} + {1'b0, be} + 33'(sub | cin);
        r.sum   = full[31:0] & mask;
        r.carry = full[n];
        r.ovf   = (a[n-1] == be[n-1]) && (r.sum[n-1] != a[n-1]);
        return r;
    endfunction

    // One clock on the 8-bit DUT with scoreboard and stall-stability checks.
    task automatic step8(output logic fired);
        logic       outf, hold, pc;
        logic [7:0] ps;
        res_t       e;
        #1;
        fired = u8_valid && u8_rdy;
        outf  = u8_ovalid && u8_dready;
        hold  = u8_ovalid && !u8_dready;
        ps    = u8_sum;
        pc    = u8_carry;
        if (outf) begin
            rx8++;
            if (q8.size() == 0) begin
                check("u8_unexpected_beat", 32'(u8_ovalid), 32'd0);
            end else begin
                e = q8.pop_front();
                check("u8_sum", 32'(u8_sum), e.sum);
                check("u8_carry", 32'(u8_carry), 32'(e.carry));
`ifdef MATH_ADDER_BK_OVF_EN
                check("u8_ovf", 32'(u8_ovf), 32'(e.ovf));
`endif
            end
        end
        if (fired) q8.push_back(model(8, 32'(u8_opa), 32'(u8_opb), u8_cin, u8_sub));
        @(posedge clk);
        #1;
        if (hold) begin
            check("u8_hold_valid", 32'(u8_ovalid), 32'd1);
            check("u8_hold_sum", 32'(u8_sum), 32'(ps));
            check("u8_hold_carry", 32'(u8_carry), 32'(pc));
        end
    endtask

    // One clock on the 32-bit DUT with scoreboard and stall-stability checks.
    task automatic step32(output logic fired);
        logic        outf, hold, pc;
        logic [31:0] ps;
        res_t        e;
        #1;
        fired = u32_valid && u32_rdy;
        outf  = u32_ovalid && u32_dready;
        hold  = u32_ovalid && !u32_dready;
        ps    = u32_sum;
        pc    = u32_carry;
        if (outf) begin
            rx32++;
            if (q32.size() == 0) begin
                check("u32_unexpected_beat", 32'(u32_ovalid), 32'd0);
            end else begin
                e = q32.pop_front();
                check("u32_sum", u32_sum, e.sum);
                check("u32_carry", 32'(u32_carry), 32'(e.carry));
`ifdef MATH_ADDER_BK_OVF_EN
                check("u32_ovf", 32'(u32_ovf), 32'(e.ovf));
`endif
            end
        end
        if (fired) q32.push_back(model(32, u32_opa, u32_opb, u32_cin, u32_sub));
        @(posedge clk);
        #1;
        if (hold) begin
            check("u32_hold_sum", u32_sum, ps);
            check("u32_hold_carry", 32'(u32_carry), 32'(pc));
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, sent, cyc, acc;
        logic f;
        logic [3:0] pat;

        //          a      b      cin   sub   sum    carry ovf
        vecs[0]  = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[2]  = {8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = {8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
        vecs[5]  = {8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[6]  = {8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7]  = {8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8]  = {8'h0F, 8'hF0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
        vecs[9]  = {8'hAA, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};
        vecs[10] = {8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};

        n_checks = 0; n_errors = 0; rx8 = 0; rx32 = 0;
        rst_n = 1'b0;
        u8_valid = 1'b0; u8_opa = '0; u8_opb = '0; u8_cin = 1'b0; u8_sub = 1'b0; u8_dready = 1'b1;
        u32_valid = 1'b0; u32_opa = '0; u32_opb = '0; u32_cin = 1'b0; u32_sub = 1'b0; u32_dready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_u8_valid", 32'(u8_ovalid), 32'd0);
        check("rst_u8_sum", 32'(u8_sum), 32'd0);
        check("rst_u8_carry", 32'(u8_carry), 32'd0);
        check("rst_u32_valid", 32'(u32_ovalid), 32'd0);
        check("rst_u32_sum", u32_sum, 32'd0);
        check("rst_u32_carry", 32'(u32_carry), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_u8_ready", 32'(u8_rdy), 32'd1);
        check("rst_u32_ready", 32'(u32_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, one beat at a time, with latency measurement
        for (int i = 0; i < 11; i++) begin
            u8_opa = vecs[i].a; u8_opb = vecs[i].b; u8_cin = vecs[i].cin; u8_sub = vecs[i].sub;
            u8_valid = 1'b1; u8_dready = 1'b1;
            #1;
            check("t1_in_ready", 32'(u8_rdy), 32'd1);
            @(posedge clk);
            #1;
            u8_valid = 1'b0;
            lat = 1;
            while (!u8_ovalid && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("t1_latency", 32'(lat), 32'd3);
            check("t1_sum", 32'(u8_sum), 32'(vecs[i].sum));
            check("t1_carry", 32'(u8_carry), 32'(vecs[i].carry));
`ifdef MATH_ADDER_BK_OVF_EN
            check("t1_ovf", 32'(u8_ovf), 32'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
        end

        // Back-pressure: 10 beats, output ready pattern 1,0,0,1
        pat = 4'b1001;
        sent = 0; rx8 = 0; cyc = 0;
        while ((sent < 10 || rx8 < 10) && cyc < 200) begin
            u8_valid  = (sent < 10);
            u8_opa    = 8'(sent * 37 + 5);
            u8_opb    = 8'(sent * 11);
            u8_sub    = sent[0];
            u8_cin    = sent[1];
            u8_dready = pat[cyc % 4];
            step8(f);
            if (f) sent++;
            cyc++;
        end
        check("t3_received", 32'(rx8), 32'd10);
        check("t3_queue_empty", 32'(q8.size()), 32'd0);

        // Full-pipe stall then release with no bubble
        u8_dready = 1'b0; u8_valid = 1'b1; acc = 0;
        for (int c = 0; c < 8; c++) begin
            u8_opa = 8'(8'h30 + c); u8_opb = 8'(8'hC5 - c); u8_cin = 1'b1; u8_sub = c[0];
            step8(f);
            if (f) acc++;
        end
        check("t4_accepts", 32'(acc), 32'd3);
        check("t4_ready_low", 32'(u8_rdy), 32'd0);
        check("t4_valid_held", 32'(u8_ovalid), 32'd1);
        u8_dready = 1'b1;
        rx8 = 0;
        for (int c = 0; c < 6; c++) begin
            u8_opa = 8'(8'h91 + 3 * c); u8_opb = 8'(8'h6E + c); u8_cin = c[1]; u8_sub = c[0];
            check("t4_no_bubble", 32'(u8_ovalid), 32'd1);
            step8(f);
            check("t4_accept_each", 32'(f), 32'd1);
        end
        u8_valid = 1'b0;
        cyc = 0;
        while (q8.size() != 0 && cyc < 10) begin
            step8(f);
            cyc++;
        end
        check("t4_received", 32'(rx8), 32'd9);

        // 32-bit instance without mid register: latency then random traffic
        u32_opa = 32'h7FFF_FFFF; u32_opb = 32'h0000_0001; u32_cin = 1'b0; u32_sub = 1'b0;
        u32_valid = 1'b1; u32_dready = 1'b1;
        @(posedge clk);
        #1;
        u32_valid = 1'b0;
        lat = 1;
        while (!u32_ovalid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t6_latency", 32'(lat), 32'd2);
        check("t6_sum", u32_sum, 32'h8000_0000);
        check("t6_carry", 32'(u32_carry), 32'd0);
`ifdef MATH_ADDER_BK_OVF_EN
        check("t6_ovf", 32'(u32_ovf), 32'd1);
`endif
        @(posedge clk);
        #1;
        sent = 0; rx32 = 0; cyc = 0;
        while ((sent < 1500 || rx32 < 1500) && cyc < 20000) begin
            u32_valid  = (sent < 1500) && ($urandom_range(0, 3) != 0);
            u32_opa    = pick32();
            u32_opb    = pick32();
            u32_cin    = 1'($urandom_range(0, 1));
            u32_sub    = 1'($urandom_range(0, 1));
            u32_dready = ($urandom_range(0, 3) != 0);
            step32(f);
            if (f) sent++;
            cyc++;
        end
        check("t6_received", 32'(rx32), 32'd1500);
        u32_valid = 1'b0;

        // Reset mid-stream with beats in flight
        u8_dready = 1'b0; u8_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            u8_opa = 8'(8'h10 + c); u8_opb = 8'h22; u8_cin = 1'b0; u8_sub = 1'b0;
            @(posedge clk);
            #1;
        end
        u8_valid = 1'b0;
        check("t5_pre_valid", 32'(u8_ovalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid_drop", 32'(u8_ovalid), 32'd0);
        check("t5_sum_clear", 32'(u8_sum), 32'd0);
        check("t5_u32_valid", 32'(u32_ovalid), 32'd0);
        q8.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        u8_dready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step8(f);
            check("t5_no_stale", 32'(u8_ovalid), 32'd0);
        end
        rx8 = 0;
        u8_valid = 1'b1; u8_opa = 8'h21; u8_opb = 8'h11; u8_cin = 1'b0; u8_sub = 1'b0;
        step8(f);
        check("t5_new_accept", 32'(f), 32'd1);
        u8_valid = 1'b0;
        cyc = 0;
        while (rx8 == 0 && cyc < 10) begin
            step8(f);
            cyc++;
        end
        check("t5_new_beat", 32'(rx8), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
